// File: rtl/scramble_sequencer.sv
// scramble_sequencer: issues a programmable number of pseudo-random face turns
// to the move-apply controller. Codes come from a free-running seedable LFSR;
// out-of-range codes and codes that undo the previous move are redrawn, and a
// fixed gap of idle cycles separates accepted moves.
module scramble_sequencer #(
  parameter int                LFSR_W    = 8,
  parameter logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8,
  parameter int                NUM_CODES = 12,
  parameter int                CNT_W     = 6,
  parameter int                GAP_CYC   = 25000000,
  parameter int                GAP_W     = 25
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic [CNT_W-1:0]  length,
  output logic              move_valid,
  output logic [3:0]        move_code,
  input  logic              move_ready,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  moves_issued,
  output logic [2:0]        state_dbg
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] DRAW  = 3'd1;
  localparam logic [2:0] ISSUE = 3'd2;
  localparam logic [2:0] GAP   = 3'd3;
  localparam logic [2:0] FIN   = 3'd4;

  localparam logic [4:0]       CODE_LIMIT = 5'(NUM_CODES);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(GAP_CYC - 1);

  // Handshake: move_valid is high for the whole ISSUE state and move_code is
  // held stable until a cycle where move_valid & move_ready are both high;
  // that cycle is the transfer, and move_valid is low in the following cycle.

  logic [2:0]        state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic [3:0]        code_q, code_d;
  logic              prev_valid_q, prev_valid_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [GAP_W-1:0]  gap_q, gap_d;

  logic [3:0]        cand;
  logic              cand_ok;
  logic [CNT_W-1:0]  cnt_inc;

  // LFSR next value: free-running step, overridden by a seed load (zero seed
  // maps to all-ones so the register can never lock up).
  always_comb begin
    lfsr_d = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};
    if (seed_load) begin
      lfsr_d = (seed == '0) ? '1 : seed;
    end
  end

  // Candidate filter: in range, and not the inverse of the last issued move
  // (code_q doubles as the previous move once prev_valid_q is set).
  always_comb begin
    cand    = lfsr_q[3:0];
    cand_ok = ({1'b0, cand} < CODE_LIMIT) &&
              (!prev_valid_q || (cand != (code_q ^ 4'b0001)));
  end

  // Sequencer FSM: abort overrides every normal transition.
  always_comb begin
    state_d      = state_q;
    code_d       = code_q;
    prev_valid_d = prev_valid_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    gap_d        = gap_q;
    cnt_inc      = cnt_q + CNT_W'(1);
    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            cnt_d        = '0;
            prev_valid_d = 1'b0;
            len_d        = length;
            state_d      = (length == '0) ? FIN : DRAW;
          end
        end
        DRAW: begin
          if (cand_ok) begin
            code_d       = cand;
            prev_valid_d = 1'b1;
            state_d      = ISSUE;
          end
        end
        ISSUE: begin
          if (move_ready) begin
            cnt_d = cnt_inc;
            if (cnt_inc == len_q) begin
              state_d = FIN;
            end else begin
              state_d = GAP;
              gap_d   = '0;
            end
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST) begin
            state_d = DRAW;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
        FIN: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      lfsr_q       <= '1;
      code_q       <= '0;
      prev_valid_q <= 1'b0;
      len_q        <= '0;
      cnt_q        <= '0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      code_q       <= code_d;
      prev_valid_q <= prev_valid_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
    end
  end

  // Outputs decode directly from registered state.
  always_comb begin
    move_valid   = (state_q == ISSUE);
    move_code    = code_q;
    busy         = (state_q != IDLE);
    done         = (state_q == FIN);
    moves_issued = cnt_q;
    state_dbg    = state_q;
  end

endmodule

// File: tb/tb_scramble_sequencer.sv
// Directed bench for scramble_sequencer with a 3-cycle gap.
module tb_scramble_sequencer;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       seed_load = 1'b0;
  logic [7:0] seed = 8'h00;
  logic [5:0] length = 6'd0;
  logic       move_ready = 1'b0;
  logic       move_valid;
  logic [3:0] move_code;
  logic       busy;
  logic       done;
  logic [5:0] moves_issued;
  logic [2:0] state_dbg;

  always #5 clock = ~clock;

  scramble_sequencer #(
    .LFSR_W(8), .LFSR_TAPS(8'hB8), .NUM_CODES(12), .CNT_W(6),
    .GAP_CYC(3), .GAP_W(4)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort),
    .seed_load(seed_load), .seed(seed), .length(length),
    .move_valid(move_valid), .move_code(move_code), .move_ready(move_ready),
    .busy(busy), .done(done), .moves_issued(moves_issued), .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- monitor / scoreboard ----------------
  logic [3:0] code_q[$];
  logic [3:0] exp_q[$];
  int         hs_q[$];
  int         rise_q[$];
  int         done_q[$];
  logic       last_valid = 1'b0;

  // Sampled on the falling edge, away from the active edge.
  always @(negedge clock) begin
    if (move_valid && move_ready && !abort && !reset) begin
      code_q.push_back(move_code);
      hs_q.push_back(cyc);
    end
    if (move_valid && !last_valid) rise_q.push_back(cyc);
    if (done) done_q.push_back(cyc);
    last_valid = move_valid;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_log();
    code_q.delete();
    hs_q.delete();
    rise_q.delete();
    done_q.delete();
    exp_q.delete();
  endtask

  task automatic load_seed(input logic [7:0] s);
    seed      = s;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
  endtask

  // Returns the cycle number of the cycle right after the edge sampling start.
  task automatic start_run(input logic [5:0] len, output int t_start);
    length = len;
    start  = 1'b1;
    tick();
    start   = 1'b0;
    t_start = cyc;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done_q.size() == 0 && n < budget) begin
      tick();
      n++;
    end
    check_val({tag, "_done_seen"}, 32'(done_q.size() != 0), 32'd1);
    tick();
  endtask

  // ---------------- test sequence ----------------
  logic [7:0] seeds[4];
  logic [3:0] held_code;
  int         t0;
  int         n_hold;
  int         bad_range;
  int         inv_pairs;
  int         min_gap;
  int         n;
  logic [3:0] e;

  initial begin
    seeds[0] = 8'h01; seeds[1] = 8'hA5; seeds[2] = 8'h3C; seeds[3] = 8'hFE;

    // Reset state
    tick(); tick();
    check_val("rst_valid", 32'(move_valid), 32'd0);
    check_val("rst_code", 32'(move_code), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_done", 32'(done), 32'd0);
    check_val("rst_count", 32'(moves_issued), 32'd0);
    check_val("rst_lfsr", 32'(dut.lfsr_q), 32'hFF);
    check_val("rst_state", 32'(state_dbg), 32'd0);
    reset = 1'b0;
    tick();

    // 1. zero seed -> all-ones; 5-move run with ready held high.
    // From FF the register walks FE, FC, F8: nibbles E and C are out of range,
    // 8 is taken after three draw cycles. Then F0, E1 (hs, gap0), C2, 85, and
    // 0B in the next draw: 11 is legal (inverse of 8 is 9).
    load_seed(8'h00);
    check_val("t1_seed_zero", 32'(dut.lfsr_q), 32'hFF);
    move_ready = 1'b1;
    clear_log();
    exp_q.push_back(4'd8);
    exp_q.push_back(4'd11);
    start_run(6'd5, t0);
    wait_done("t1", 300);
    check_val("t1_hs_count", 32'(code_q.size()), 32'd5);
    for (int i = 0; i < 2; i++) begin
      e = exp_q.pop_front();
      if (code_q.size() > i) check_val("t1_code", 32'(code_q[i]), 32'(e));
      else check_val("t1_code_missing", 32'(code_q.size()), 32'(i + 1));
    end
    if (rise_q.size() >= 2 && hs_q.size() >= 5) begin
      check_val("t1_first_latency", 32'(rise_q[0] - t0), 32'd3);
      check_val("t1_hs_to_valid", 32'(rise_q[1] - hs_q[0]), 32'd5);
      check_val("t1_done_time", 32'(done_q[0] - hs_q[4]), 32'd1);
    end else begin
      check_val("t1_events", 32'(rise_q.size()), 32'd5);
    end
    check_val("t1_done_count", 32'(done_q.size()), 32'd1);
    check_val("t1_moves_issued", 32'(moves_issued), 32'd5);
    check_val("t1_busy_after", 32'(busy), 32'd0);
    check_val("t1_done_after", 32'(done), 32'd0);

    // 2. back-pressure: ready low for 10 cycles while the move is offered
    clear_log();
    move_ready = 1'b0;
    start_run(6'd2, t0);
    n = 0;
    while (!move_valid && n < 100) begin
      tick();
      n++;
    end
    check_val("t2_valid_seen", 32'(move_valid), 32'd1);
    held_code = move_code;
    n_hold = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (move_valid && move_code == held_code && moves_issued == 6'd0) n_hold++;
    end
    check_val("t2_held_cycles", 32'(n_hold), 32'd10);
    check_val("t2_count_frozen", 32'(moves_issued), 32'd0);
    move_ready = 1'b1;
    wait_done("t2", 300);
    check_val("t2_hs_count", 32'(code_q.size()), 32'd2);
    if (code_q.size() > 0) check_val("t2_code_kept", 32'(code_q[0]), 32'(held_code));

    // 3. long runs over several seeds
    for (int s = 0; s < 4; s++) begin
      load_seed(seeds[s]);
      clear_log();
      start_run(6'd40, t0);
      wait_done("t3", 4000);
      bad_range = 0;
      inv_pairs = 0;
      min_gap   = 1000;
      for (int i = 0; i < code_q.size(); i++) begin
        if (code_q[i] >= 4'd12) bad_range++;
        if (i > 0 && code_q[i] == (code_q[i-1] ^ 4'd1)) inv_pairs++;
        if (i > 0 && i < rise_q.size() && (rise_q[i] - hs_q[i-1]) < min_gap)
          min_gap = rise_q[i] - hs_q[i-1];
      end
      check_val("t3_hs_count", 32'(code_q.size()), 32'd40);
      check_val("t3_moves_issued", 32'(moves_issued), 32'd40);
      check_val("t3_out_of_range", 32'(bad_range), 32'd0);
      check_val("t3_inverse_pairs", 32'(inv_pairs), 32'd0);
      check_val("t3_min_gap_ge4", 32'(min_gap >= 4), 32'd1);
    end

    // 4. abort on the cycle of the third handshake
    clear_log();
    start_run(6'd10, t0);
    n = 0;
    while (!(move_valid && code_q.size() == 2) && n < 500) begin
      tick();
      n++;
    end
    check_val("t4_third_offer", 32'(move_valid), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_val("t4_idle_busy", 32'(busy), 32'd0);
    check_val("t4_valid_low", 32'(move_valid), 32'd0);
    check_val("t4_state_idle", 32'(state_dbg), 32'd0);
    check_val("t4_moves_issued", 32'(moves_issued), 32'd2);
    tick(); tick(); tick();
    check_val("t4_no_done", 32'(done_q.size()), 32'd0);
    clear_log();
    start_run(6'd3, t0);
    wait_done("t4_rerun", 300);
    check_val("t4_rerun_hs", 32'(code_q.size()), 32'd3);
    check_val("t4_rerun_count", 32'(moves_issued), 32'd3);

    // 5. zero-length scramble: done in the cycle after start is sampled
    clear_log();
    start_run(6'd0, t0);
    for (int i = 0; i < 5; i++) tick();
    check_val("t5_no_valid", 32'(rise_q.size()), 32'd0);
    check_val("t5_done_count", 32'(done_q.size()), 32'd1);
    if (done_q.size() > 0) check_val("t5_done_time", 32'(done_q[0] - t0), 32'd0);
    check_val("t5_busy_after", 32'(busy), 32'd0);

    // 6a. start and a new length applied mid-scramble are ignored
    clear_log();
    start_run(6'd4, t0);
    n = 0;
    while (code_q.size() == 0 && n < 200) begin
      tick();
      n++;
    end
    length = 6'd1;
    start  = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t6", 400);
    check_val("t6_hs_count", 32'(code_q.size()), 32'd4);
    check_val("t6_moves_issued", 32'(moves_issued), 32'd4);
    check_val("t6_done_count", 32'(done_q.size()), 32'd1);

    // 6b. reset while in the gap
    clear_log();
    start_run(6'd5, t0);
    n = 0;
    while (!(code_q.size() == 1 && busy && !move_valid) && n < 200) begin
      tick();
      n++;
    end
    check_val("t6_in_gap", 32'(state_dbg), 32'd3);
    reset = 1'b1;
    tick();
    check_val("t6_rst_valid", 32'(move_valid), 32'd0);
    check_val("t6_rst_code", 32'(move_code), 32'd0);
    check_val("t6_rst_busy", 32'(busy), 32'd0);
    check_val("t6_rst_done", 32'(done), 32'd0);
    check_val("t6_rst_count", 32'(moves_issued), 32'd0);
    check_val("t6_rst_lfsr", 32'(dut.lfsr_q), 32'hFF);
    check_val("t6_rst_state", 32'(state_dbg), 32'd0);
    reset = 1'b0;
    tick();

    // ---------------- report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard stop in case a wait is never satisfied.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
